// File: rtl/s27_bist_ctrl.sv
// Built-in self-test sequencer for the s27 core: initialises the core flops, applies
// LFSR vectors, compacts G17 into an 8-bit MISR and compares it with a golden signature.
module s27_bist_ctrl #(
    parameter int         NUM_PATTERNS = 255,
    parameter int         INIT_CYCLES  = 2,
    parameter logic [7:0] LFSR_SEED    = 8'h01,
    parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       core_out_i,
    output logic [3:0] pat_o,
    output logic       core_rstn_o,
    output logic       core_setn_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] sig_o
);
    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0]    SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [15:0]   CNT_LAST  = 16'(NUM_PATTERNS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CMP
    } state_t;

    state_t        r_state, w_state_next;
    logic [7:0]    r_lfsr, w_lfsr_next;
    logic [7:0]    r_misr, w_misr_next;
    logic [15:0]   r_cnt, w_cnt_next;
    logic [IW-1:0] r_init_cnt, w_init_cnt_next;
    logic [3:0]    r_pat, w_pat_next;
    logic          r_core_rstn, w_core_rstn_next;
    logic          r_core_setn, w_core_setn_next;
    logic          r_done, w_done_next;
    logic          r_pass, w_pass_next;

    logic [7:0]    w_lfsr_step;
    logic [7:0]    w_misr_step;
    logic [15:0]   w_cnt_inc;

    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_misr_step = {r_misr[6:0], r_misr[7] ^ r_misr[5] ^ r_misr[4] ^ r_misr[3]}
                         ^ {7'b0, core_out_i};
    assign w_cnt_inc   = r_cnt + 16'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_lfsr_next      = r_lfsr;
        w_misr_next      = r_misr;
        w_cnt_next       = r_cnt;
        w_init_cnt_next  = r_init_cnt;
        w_pat_next       = r_pat;
        w_core_rstn_next = r_core_rstn;
        w_core_setn_next = r_core_setn;
        w_done_next      = 1'b0;
        w_pass_next      = r_pass;

        // Abort wins over start and over completion; the partial signature is kept.
        if (abort_i) begin
            w_state_next     = S_IDLE;
            w_pat_next       = 4'h0;
            w_core_rstn_next = 1'b1;
            w_core_setn_next = 1'b1;
            w_pass_next      = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_next     = S_INIT;
                        w_misr_next      = 8'h00;
                        w_cnt_next       = 16'd0;
                        w_init_cnt_next  = '0;
                        w_pass_next      = 1'b0;
                        w_lfsr_next      = SEED;
                        w_pat_next       = 4'h0;
                        w_core_rstn_next = 1'b0;
                        w_core_setn_next = 1'b0;
                    end
                end
                S_INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        w_state_next     = S_RUN;
                        w_pat_next       = r_lfsr[3:0];
                        w_core_rstn_next = 1'b1;
                        w_core_setn_next = 1'b1;
                    end else begin
                        w_init_cnt_next = r_init_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The response to the vector on pat_o is captured on this same edge.
                    w_misr_next = w_misr_step;
                    w_lfsr_next = w_lfsr_step;
                    w_cnt_next  = w_cnt_inc;
                    if (w_cnt_inc == CNT_LAST) begin
                        w_state_next = S_CMP;
                        w_pat_next   = 4'h0;
                    end else begin
                        w_pat_next = w_lfsr_step[3:0];
                    end
                end
                S_CMP: begin
                    w_state_next = S_IDLE;
                    w_pass_next  = (r_misr == GOLDEN_SIG);
                    w_done_next  = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr      <= SEED;
            r_misr      <= 8'h00;
            r_cnt       <= 16'd0;
            r_init_cnt  <= '0;
            r_pat       <= 4'h0;
            r_core_rstn <= 1'b1;
            r_core_setn <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_misr      <= w_misr_next;
            r_cnt       <= w_cnt_next;
            r_init_cnt  <= w_init_cnt_next;
            r_pat       <= w_pat_next;
            r_core_rstn <= w_core_rstn_next;
            r_core_setn <= w_core_setn_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
        end
    end

    assign pat_o       = r_pat;
    assign core_rstn_o = r_core_rstn;
    assign core_setn_o = r_core_setn;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign sig_o       = r_misr;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: directed runs with constant, random and s27-driven responses,
// checked against an arithmetic LFSR/MISR model and a behavioural s27 model.
module tb_s27_bist_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start_i;
    logic       abort_i;
    logic       core_rand;
    int         mode_sel;

    logic [3:0] pat_m, pat_1, pat_2;
    logic       rn_m, sn_m, busy_m, done_m, pass_m;
    logic       rn_1, sn_1, busy_1, done_1, pass_1;
    logic       rn_2, sn_2, busy_2, done_2, pass_2;
    logic [7:0] sig_m, sig_1, sig_2;
    logic       core_out_m;
    logic       one_c;

    logic [2:0] core_st = 3'b000;
    logic [3:0] core_eval;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_m_cnt = 0, done_m_cyc = 0;
    int done_1_cyc = 0, done_2_cyc = 0;
    int t0 = 0;
    int dbase = 0;

    always #5 clk = ~clk;

    s27_bist_ctrl dut_m (
        .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i), .core_out_i(core_out_m),
        .pat_o(pat_m), .core_rstn_o(rn_m), .core_setn_o(sn_m), .busy_o(busy_m),
        .done_o(done_m), .pass_o(pass_m), .sig_o(sig_m)
    );

    s27_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(8'h00), .GOLDEN_SIG(8'h00)) dut_1 (
        .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i), .core_out_i(one_c),
        .pat_o(pat_1), .core_rstn_o(rn_1), .core_setn_o(sn_1), .busy_o(busy_1),
        .done_o(done_1), .pass_o(pass_1), .sig_o(sig_1)
    );

    s27_bist_ctrl #(.NUM_PATTERNS(2), .GOLDEN_SIG(8'h03)) dut_2 (
        .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i), .core_out_i(one_c),
        .pat_o(pat_2), .core_rstn_o(rn_2), .core_setn_o(sn_2), .busy_o(busy_2),
        .done_o(done_2), .pass_o(pass_2), .sig_o(sig_2)
    );

    // s27 gate netlist; st = {G7,G6,G5}, g = {G3,G2,G1,G0}; returns {G13,G11,G10,G17}.
    function automatic logic [3:0] s27_eval(input logic [2:0] st, input logic [3:0] g);
        logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g14 = ~g[0];
        g8  = g14 & st[1];
        g12 = ~(g[1] | st[2]);
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[0] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {g13, g11, g10, ~g11};
    endfunction

    // Shift-left-with-feedback over taps 7,5,4,3, plus an injected bit in position 0.
    function automatic logic [7:0] step8(input logic [7:0] x, input logic in_bit);
        int v;
        v = (int'(x) * 2) % 256 + int'(^(x & 8'hB8));
        return 8'(v) ^ {7'd0, in_bit};
    endfunction

    assign one_c      = 1'b1;
    assign core_eval  = s27_eval(core_st, pat_m);
    assign core_out_m = (mode_sel == 2) ? core_eval[0] : core_rand;

    // Core flops: G5 cleared by RN, G6/G7 set by SN.
    always @(posedge clk) begin
        core_st[0] <= rn_m ? core_eval[1] : 1'b0;
        core_st[1] <= sn_m ? core_eval[2] : 1'b1;
        core_st[2] <= sn_m ? core_eval[3] : 1'b1;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (done_m === 1'b1) begin
            done_m_cnt = done_m_cnt + 1;
            done_m_cyc = cyc;
        end
        if (done_1 === 1'b1) done_1_cyc = cyc;
        if (done_2 === 1'b1) done_2_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_pat"},  32'(pat_m), 32'h0);
        check({pfx, "_pins"}, 32'({rn_m, sn_m}), 32'h3);
        check({pfx, "_busy"}, 32'(busy_m), 32'h0);
        check({pfx, "_done"}, 32'(done_m), 32'h0);
        check({pfx, "_pass"}, 32'(pass_m), 32'h0);
        check({pfx, "_sig"},  32'(sig_m), 32'h0);
    endtask

    // One run of the 255-vector controller: mode 0 = response 0, 1 = random, 2 = s27.
    // abort_at/start_at/rst_at name the vector index for that event (-1 = none);
    // abort_at = 255 aborts during the compare cycle.
    task automatic do_run(input int mode, input int abort_at, input int start_at, input int rst_at);
        logic [7:0] lfsr_m;
        logic [7:0] misr_m;
        logic [2:0] st;
        logic [3:0] e;
        logic       b;
        lfsr_m    = 8'h01;
        misr_m    = 8'h00;
        st        = 3'b110;
        mode_sel  = mode;
        core_rand = 1'b0;
        dbase     = done_m_cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        t0 = cyc;
        check("init_busy", 32'(busy_m), 32'h1);
        check("init_pins_a", 32'({rn_m, sn_m}), 32'h0);
        check("init_pat", 32'(pat_m), 32'h0);
        tick();
        check("init_pins_b", 32'({rn_m, sn_m}), 32'h0);
        tick();
        for (int k = 0; k < 255; k++) begin
            check("pat_vec", 32'(pat_m), 32'(lfsr_m[3:0]));
            if (k == 0) begin
                check("run_pins", 32'({rn_m, sn_m}), 32'h3);
                check("seed0_pat", 32'(pat_1), 32'h1);
            end
            if (k == rst_at) begin
                #2 rstn = 1'b0;
                #1 check_reset("midrst");
                #2 rstn = 1'b1;
                return;
            end
            if (k == start_at) start_i = 1'b1;
            case (mode)
                1:       b = 1'($urandom_range(1, 0));
                2: begin
                    e = s27_eval(st, lfsr_m[3:0]);
                    b = e[0];
                    st = e[3:1];
                end
                default: b = 1'b0;
            endcase
            core_rand = b;
            if (k == abort_at) begin
                abort_i = 1'b1;
                tick();
                abort_i = 1'b0;
                check("abort_busy", 32'(busy_m), 32'h0);
                check("abort_pat", 32'(pat_m), 32'h0);
                check("abort_pins", 32'({rn_m, sn_m}), 32'h3);
                check("abort_pass", 32'(pass_m), 32'h0);
                check("abort_sig", 32'(sig_m), 32'(misr_m));
                return;
            end
            misr_m = step8(misr_m, b);
            lfsr_m = step8(lfsr_m, 1'b0);
            tick();
            start_i = 1'b0;
        end
        check("cmp_pat", 32'(pat_m), 32'h0);
        check("cmp_busy", 32'(busy_m), 32'h1);
        check("cmp_done", 32'(done_m), 32'h0);
        check("cmp_sig", 32'(sig_m), 32'(misr_m));
        if (abort_at == 255) begin
            abort_i = 1'b1;
            tick();
            abort_i = 1'b0;
            check("abortcmp_done", 32'(done_m), 32'h0);
            check("abortcmp_busy", 32'(busy_m), 32'h0);
            check("abortcmp_pass", 32'(pass_m), 32'h0);
            return;
        end
        tick();
        check("end_done", 32'(done_m), 32'h1);
        check("end_busy", 32'(busy_m), 32'h0);
        check("end_sig", 32'(sig_m), 32'(misr_m));
        check("end_pass", 32'(pass_m), 32'(misr_m == 8'h00));
        tick();
        check("done_pulse", 32'(done_m), 32'h0);
        check("done_count", 32'(done_m_cnt - dbase), 32'h1);
        check("done_latency", 32'(done_m_cyc - t0), 32'd258);
        check("hold_sig", 32'(sig_m), 32'(misr_m));
    endtask

    initial begin
        start_i   = 1'b0;
        abort_i   = 1'b0;
        core_rand = 1'b0;
        mode_sel  = 0;
        rstn      = 1'b1;
        #1 rstn = 1'b0;
        #2 check_reset("reset");
        #14 rstn = 1'b1;
        tick();
        check_reset("post_reset");

        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_over_start", 32'(busy_m), 32'h0);

        do_run(0, -1, -1, -1);
        check("np1_sig", 32'(sig_1), 32'h01);
        check("np1_pass", 32'(pass_1), 32'h0);
        check("np1_latency", 32'(done_1_cyc - t0), 32'd4);
        check("np2_sig", 32'(sig_2), 32'h03);
        check("np2_pass", 32'(pass_2), 32'h1);
        check("np2_latency", 32'(done_2_cyc - t0), 32'd5);

        do_run(1, -1, -1, -1);

        do_run(1, 10, -1, -1);
        repeat (5) tick();
        check("abort_no_done", 32'(done_m_cnt - dbase), 32'h0);
        check("abort_idle_pat", 32'(pat_m), 32'h0);

        do_run(1, -1, 40, -1);
        do_run(1, -1, -1, 77);
        tick();
        check_reset("after_rst");
        do_run(2, -1, -1, -1);
        do_run(2, -1, -1, -1);

        do_run(0, 255, -1, -1);
        repeat (3) tick();
        check("abortcmp_no_done", 32'(done_m_cnt - dbase), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
